// File: rtl/instr_encoder.sv
// MIPS instruction encoder: mnemonic ID plus operand fields in, 32-bit machine word out,
// through a 2-entry in-order output buffer with emitted/illegal counters.
module instr_encoder #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [4:0]       Mnemonic,
    input  logic [4:0]       Rs,
    input  logic [4:0]       Rt,
    input  logic [4:0]       Rd,
    input  logic [4:0]       Shamt,
    input  logic [15:0]      Imm,
    input  logic [25:0]      Target,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [31:0]      Instruction,
    output logic             Illegal,
    output logic [CNT_W-1:0] EmitCount,
    output logic [CNT_W-1:0] IllegalCount
);

    logic [31:0]      word;
    logic             legal;
    logic [31:0]      mem_q [2];
    logic             rd_ptr_q, wr_ptr_q;
    logic [1:0]       count_q, count_d;
    logic             illegal_q;
    logic [CNT_W-1:0] emit_q, ill_cnt_q;
    logic             accept, push, pop;

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (Mnemonic)
            5'd0:  word = {6'h00, Rs, Rt, Rd, 5'd0, 6'h20};
            5'd1:  word = {6'h00, Rs, Rt, Rd, 5'd0, 6'h22};
            5'd2:  word = {6'h1C, Rs, Rt, Rd, 5'd0, 6'h18};
            5'd3:  word = {6'h00, Rs, Rt, Rd, 5'd0, 6'h24};
            5'd4:  word = {6'h00, Rs, Rt, Rd, 5'd0, 6'h25};
            5'd5:  word = {6'h00, Rs, Rt, Rd, 5'd0, 6'h27};
            5'd6:  word = {6'h00, Rs, Rt, Rd, 5'd0, 6'h26};
            5'd7:  word = {6'h00, 5'd0, Rt, Rd, Shamt, 6'h00};
            5'd8:  word = {6'h00, 5'd0, Rt, Rd, Shamt, 6'h02};
            5'd9:  word = {6'h00, Rs, Rt, Rd, 5'd0, 6'h2A};
            5'd10: word = {6'h00, Rs, 15'd0, 6'h08};
            5'd11: word = {6'h01, Rs, 5'd0, Imm};
            5'd12: word = {6'h01, Rs, 5'd1, Imm};
            5'd13: word = {6'h03, Target};
            5'd14: word = {6'h08, Rs, Rt, Imm};
            5'd15: word = {6'h0C, Rs, Rt, Imm};
            5'd16: word = {6'h0D, Rs, Rt, Imm};
            5'd17: word = {6'h0E, Rs, Rt, Imm};
            5'd18: word = {6'h0A, Rs, Rt, Imm};
            5'd19: word = {6'h23, Rs, Rt, Imm};
            5'd20: word = {6'h2B, Rs, Rt, Imm};
            5'd21: word = {6'h28, Rs, Rt, Imm};
            5'd22: word = {6'h21, Rs, Rt, Imm};
            5'd23: word = {6'h20, Rs, Rt, Imm};
            5'd24: word = {6'h29, Rs, Rt, Imm};
            5'd25: word = {6'h04, Rs, Rt, Imm};
            5'd26: word = {6'h05, Rs, Rt, Imm};
            5'd27: word = {6'h07, Rs, 5'd0, Imm};
            5'd28: word = {6'h06, Rs, 5'd0, Imm};
            5'd29: word = {6'h02, Target};
            default: legal = 1'b0;
        endcase
    end

    // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot.
    assign InReady     = Rst_n && (count_q < 2'(DEPTH));
    assign OutValid    = (count_q != 2'd0);
    assign Instruction = OutValid ? mem_q[rd_ptr_q] : 32'd0;
    assign Illegal     = illegal_q;
    assign EmitCount   = emit_q;
    assign IllegalCount = ill_cnt_q;

    assign accept = InValid && InReady;
    assign push   = accept && legal;
    assign pop    = OutValid && OutReady;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            illegal_q <= 1'b0;
            emit_q    <= '0;
            ill_cnt_q <= '0;
        end else begin
            count_q   <= count_d;
            illegal_q <= accept && !legal;
            if (push) begin
                mem_q[wr_ptr_q] <= word;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
                emit_q   <= emit_q + 1'b1;
            end
            if (accept && !legal) begin
                ill_cnt_q <= ill_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Builds 32-bit MIPS machine words from a mnemonic ID and operand fields. It is the encoding counterpart of the Controller decoder and covers exactly the 30 instructions the Controller supports. It feeds instruction memory initialisation and the Controller/datapath benches through a valid/ready stream with a 2-entry output buffer. Illegal mnemonics are flagged and counted, never emitted.

Parameters:
DEPTH, 2, output buffer entries (fixed 2; other values unsupported)
CNT_W, 16, width of emitted/illegal counters

Ports:
Clk  in  1  clock, rising edge
Rst_n  in  1  asynchronous reset, active-low
InValid  in  1  request present
InReady  out  1  encoder can accept a request
Mnemonic  in  5  instruction ID (table below)
Rs  in  5  rs field
Rt  in  5  rt field
Rd  in  5  rd field
Shamt  in  5  shift amount
Imm  in  16  immediate / branch offset / load-store offset
Target  in  26  jump target
OutValid  out  1  Instruction holds a valid word
OutReady  in  1  consumer accepts Instruction
Instruction  out  32  encoded word (buffer head)
Illegal  out  1  one-cycle pulse: illegal mnemonic consumed
EmitCount  out  CNT_W  words handed out (OutValid&OutReady)
IllegalCount  out  CNT_W  illegal requests consumed

Behaviour:
- Mnemonic table (op/funct hex). R-type op=00: 0 add f20, 1 sub f22, 3 and f24, 4 or f25, 5 nor f27, 6 xor f26, 7 sll f00, 8 srl f02, 9 slt f2A, 10 jr f08. 2 mul: op 1C, f18.
- REGIMM op=01: 11 bltz rt=00000, 12 bgez rt=00001.
- J-type: 13 jal op03, 29 j op02.
- I-type: 14 addi 08, 15 andi 0C, 16 ori 0D, 17 xori 0E, 18 slti 0A, 19 lw 23, 20 sw 2B, 21 sb 28, 22 lh 21, 23 lb 20, 24 sh 29, 25 beq 04, 26 bne 05, 27 bgtz 07, 28 blez 06.
- 30, 31: illegal.
- Field forcing:
  - R-type: op|Rs|Rt|Rd|Shamt|funct. Shamt forced 0 except sll/srl; Rs forced 0 for sll/srl.
  - jr: Rs kept; rt, rd, shamt forced 0.
  - bltz/bgez/bgtz/blez: rt field from table/0, Rt input ignored.
  - I-type: op|Rs|Rt|Imm.
  - J-type: op|Target.
- Handshake:
  - Accept when InValid&InReady.
  - InReady = (occupancy < 2), combinational from registered occupancy only, never from OutReady.
  - Pop when OutValid&OutReady.
- Latency: a legal request accepted at edge N appears on Instruction after edge N, so it is visible in cycle N+1.
- Buffer: 2-entry FIFO, in-order.
  - OutValid = occupancy != 0.
  - Instruction = head entry, held stable while OutValid&!OutReady.
- Simultaneous push+pop: occupancy unchanged; ordering preserved. At occupancy 1 the new word becomes head after the pop.
- Full (occupancy 2): InReady=0. A pop in that cycle does not allow a same-cycle push.
- Illegal request accepted:
  - Nothing is written; occupancy unchanged.
  - Illegal=1 in the following cycle only.
  - IllegalCount increments.
  - Accepted even when occupancy would allow a push.
- Counters: EmitCount increments on every pop. Both counters wrap modulo 2^CNT_W.
- Reset (Rst_n low, any time, including mid-stream):
  - Buffer emptied; occupancy 0.
  - OutValid=0, Instruction=0, Illegal=0, EmitCount=0, IllegalCount=0.
  - InReady=0 while Rst_n low; InReady=1 from the first cycle after release.
  - Buffered words are discarded and never emitted.

Test Plan:
- add: Mnemonic=0, Rs=9, Rt=10, Rd=8, Shamt=5, OutReady=1 -> next cycle Instruction=32'h012A4020 (shamt forced 0), OutValid=1, EmitCount=1.
- Mixed encodings:
  - sll Rs=3, Rt=9, Rd=8, Shamt=4 -> 32'h00094100.
  - bgez Rs=8, Rt=7, Imm=0x20 -> 32'h05010020.
  - j Target=0x0100000 -> 32'h08100000.
  - mul 9,10,8 -> 32'h712A4018.
- Backpressure: OutReady=0, push lw (Rs=9, Rt=8, Imm=4 -> 8D280004) and sw (AD280004) -> InReady=0 after two accepts, Instruction holds 8D280004. Raise OutReady -> 8D280004 then AD280004, EmitCount=2.
- Push+pop at occupancy 1 each cycle for 10 back-to-back beq/bne requests -> continuous OutValid, in-order words, EmitCount=10.
- Illegal: Mnemonic=30 with occupancy 0 -> OutValid stays 0, Illegal pulses 1 cycle, IllegalCount=1. Following ori (Rs=9, Rt=8, Imm=0x000A) -> 352800 0A (32'h3528000A).
- Reset mid-operation: fill 2 entries, assert Rst_n low for 1 cycle -> all outputs 0 and the buffered words are never seen. Next add request encodes normally with EmitCount counting from 0.
